// File: rtl/alu_pkg.sv
// Shared types and constants for the byte-serial multibyte adder.
package alu_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/multibyte_adder_seq_byte_add_cin.sv
// One byte-wide add with carry in/out; the only carry path in the adder.
module byte_add_cin
    import alu_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              c_in,
    output logic [BYTE_W-1:0] sum,
    output logic              c_out
);

    logic [BYTE_W:0] total;

    assign total        = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, c_in};
    assign {c_out, sum} = total;

endmodule

// File: rtl/multibyte_adder_seq.sv
// Sequential W-bit adder: one byte per clock, LSB first, carry held in a register
// between bytes so no full-width carry chain exists.
module multibyte_adder_seq
    import alu_pkg::*;
#(
    parameter  int unsigned NBYTES = 4,
    localparam int unsigned W      = BYTE_W * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         c_out
);

    localparam int unsigned      IDX_W    = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_e            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      sum_q, sum_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [BYTE_W-1:0] byte_a;
    logic [BYTE_W-1:0] byte_b;
    logic [BYTE_W-1:0] byte_sum;
    logic              byte_cout;

    // Select the operand bytes addressed by the current index.
    always_comb begin
        byte_a = '0;
        byte_b = '0;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                byte_a = a_q[k*BYTE_W +: BYTE_W];
                byte_b = b_q[k*BYTE_W +: BYTE_W];
            end
        end
    end

    byte_add_cin u_byte_add (
        .a     (byte_a),
        .b     (byte_b),
        .c_in  (carry_q),
        .sum   (byte_sum),
        .c_out (byte_cout)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                for (int unsigned k = 0; k < NBYTES; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        sum_d[k*BYTE_W +: BYTE_W] = byte_sum;
                    end
                end
                carry_d = byte_cout;
                // Index saturates at the last byte; it is cleared on the next accept.
                if (idx_q == LAST_IDX) begin
                    cout_d  = byte_cout;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign c_out = cout_q;

endmodule
